// File: rtl/mm_seq_ctrl.sv
// Row-path sequencer for the matrix multiplier: loads each operand tile, frames
// its row stream for the MAC array, waits out the MAC pipeline, hands off the result.
module mm_seq_ctrl #(
  parameter int ROWS      = 128,
  parameter int ROW_IDX_W = 7,
  parameter int PIPE_LAT  = 4,
  parameter int TILE_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TILE_W-1:0]    tiles,
  input  logic                 operands_ready,
  output logic                 load,
  output logic                 row_valid,
  output logic [ROW_IDX_W-1:0] row_idx,
  output logic                 acc_clear,
  output logic                 acc_last,
  output logic [TILE_W-1:0]    tile_idx,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OP, S_LOAD, S_STREAM, S_DRAIN, S_RESULT
  } state_t;

  localparam logic [ROW_IDX_W-1:0] LP_ROW_LAST   = ROW_IDX_W'(ROWS - 1);
  localparam logic [3:0]           LP_DRAIN_LAST = (PIPE_LAT == 0) ? 4'd0 : 4'(PIPE_LAT - 1);

  state_t               r_state, w_nxt_state;
  logic [3:0]           r_drain, w_nxt_drain;
  logic [TILE_W-1:0]    r_tiles, w_nxt_tiles;
  logic [TILE_W-1:0]    w_nxt_tile_idx;
  logic [ROW_IDX_W-1:0] w_nxt_row;
  logic                 w_nxt_done;

  // Outputs are registered from the next-state decode so every strobe is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_drain   <= '0;
      r_tiles   <= '0;
      tile_idx  <= '0;
      row_idx   <= '0;
      load      <= 1'b0;
      row_valid <= 1'b0;
      acc_clear <= 1'b0;
      acc_last  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_drain   <= w_nxt_drain;
      r_tiles   <= w_nxt_tiles;
      tile_idx  <= w_nxt_tile_idx;
      row_idx   <= w_nxt_row;
      load      <= (w_nxt_state == S_LOAD);
      row_valid <= (w_nxt_state == S_STREAM);
      acc_clear <= (w_nxt_state == S_STREAM) && (w_nxt_row == '0);
      acc_last  <= (w_nxt_state == S_STREAM) && (w_nxt_row == LP_ROW_LAST);
      res_valid <= (w_nxt_state == S_RESULT);
      busy      <= (w_nxt_state != S_IDLE);
      done      <= w_nxt_done;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_drain    = '0;
    w_nxt_tiles    = r_tiles;
    w_nxt_tile_idx = tile_idx;
    w_nxt_row      = '0;
    w_nxt_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (tiles != '0) begin
            w_nxt_tiles    = tiles;
            w_nxt_tile_idx = '0;
            w_nxt_state    = S_WAIT_OP;
          end else begin
            w_nxt_done = 1'b1;
          end
        end
      end
      S_WAIT_OP: begin
        if (operands_ready) w_nxt_state = S_LOAD;
      end
      S_LOAD: begin
        w_nxt_state = S_STREAM;
      end
      S_STREAM: begin
        // No hold on the shift register: once streaming, every cycle is a row.
        if (row_idx == LP_ROW_LAST) begin
          w_nxt_state = (PIPE_LAT == 0) ? S_RESULT : S_DRAIN;
        end else begin
          w_nxt_row = row_idx + ROW_IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_drain == LP_DRAIN_LAST) w_nxt_state = S_RESULT;
        else                          w_nxt_drain = r_drain + 4'd1;
      end
      S_RESULT: begin
        if (res_ready) begin
          if (tile_idx == r_tiles - TILE_W'(1)) begin
            w_nxt_state = S_IDLE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_tile_idx = tile_idx + TILE_W'(1);
            w_nxt_state    = S_WAIT_OP;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

endmodule
